// File: rtl/chimera_cluster_pwr_seq.sv
// Shared power sequencer for the Chimera cluster domain: isolates, gates, resets and powers clusters in order.
// Optional build macro CHIMERA_PWR_SEQ_IRQ_EN adds a one-cycle done_irq_o pulse on every return to IDLE.
module chimera_cluster_pwr_seq #(
  parameter int unsigned NumClusters  = 5,
  parameter int unsigned SettleCycles = 16,
  parameter int unsigned HoldCycles   = 2,
  parameter int unsigned IsoTimeout   = 256,
  parameter int unsigned CntWidth     = $clog2(
      ((SettleCycles > IsoTimeout)
        ? ((SettleCycles > HoldCycles) ? SettleCycles : HoldCycles)
        : ((IsoTimeout > HoldCycles) ? IsoTimeout : HoldCycles)) + 1),
  parameter int unsigned IdxWidth     = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [IdxWidth-1:0]    cmd_cluster_i,
  input  logic                   cmd_on_i,
  output logic [NumClusters-1:0] iso_req_o,
  input  logic [NumClusters-1:0] iso_ack_i,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] rst_no,
  output logic [NumClusters-1:0] pwr_en_o,
  output logic [NumClusters-1:0] on_o,
  output logic [NumClusters-1:0] err_o,
  output logic                   busy_o
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
  ,
  output logic                   done_irq_o
`endif
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StIsoOn  = 4'd1;
  localparam logic [3:0] StClkOff = 4'd2;
  localparam logic [3:0] StRstOn  = 4'd3;
  localparam logic [3:0] StPwrOff = 4'd4;
  localparam logic [3:0] StPwrOn  = 4'd5;
  localparam logic [3:0] StClkOn  = 4'd6;
  localparam logic [3:0] StRstOff = 4'd7;
  localparam logic [3:0] StIsoOff = 4'd8;

  localparam int unsigned SyncDepth = 2;

  logic [3:0]             state_q, state_d;
  logic [IdxWidth-1:0]    tgt_q, tgt_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NumClusters-1:0] iso_req_q, iso_req_d;
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] rst_n_q, rst_n_d;
  logic [NumClusters-1:0] pwr_en_q, pwr_en_d;
  logic [NumClusters-1:0] on_q, on_d;
  logic [NumClusters-1:0] err_q, err_d;
  logic [NumClusters-1:0] ack_s1_q, ack_s2_q;
  logic                   busy_q, ready_q;
  logic                   idx_ok, ack, ack_valid;

  assign idx_ok    = (32'(cmd_cluster_i) < NumClusters);
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);
  assign ack       = ack_s2_q[tgt_q];
  // Ack values from before the request could reach the synchroniser output are stale; ignore them.
  assign ack_valid = (cnt_q >= CntWidth'(SyncDepth));

  // Asynchronous ack synchroniser
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_s1_q <= '0;
      ack_s2_q <= '0;
    end else begin
      ack_s1_q <= iso_ack_i;
      ack_s2_q <= ack_s1_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tgt_q     <= '0;
      cnt_q     <= '0;
      iso_req_q <= '0;
      clk_en_q  <= '1;
      rst_n_q   <= '1;
      pwr_en_q  <= '1;
      on_q      <= '1;
      err_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      iso_req_q <= iso_req_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      pwr_en_q  <= pwr_en_d;
      on_q      <= on_d;
      err_q     <= err_d;
      busy_q    <= (state_d != StIdle);
      ready_q   <= (state_d == StIdle);
    end
  end

  // Next-state and per-cluster output decode
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_inc;
    iso_req_d = iso_req_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    pwr_en_d  = pwr_en_q;
    on_d      = on_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cmd_valid_i && idx_ok) begin
          err_d[cmd_cluster_i] = 1'b0;
          if (on_q[cmd_cluster_i] != cmd_on_i) begin
            tgt_d   = cmd_cluster_i;
            state_d = cmd_on_i ? StPwrOn : StIsoOn;
          end
        end
      end
      StIsoOn: begin
        iso_req_d[tgt_q] = 1'b1;
        if (ack_valid && ack) begin
          state_d = StClkOff;
          cnt_d   = '0;
        end else if (cnt_q == CntWidth'(IsoTimeout)) begin
          iso_req_d[tgt_q] = 1'b0;
          err_d[tgt_q]     = 1'b1;
          state_d          = StIdle;
        end
      end
      StClkOff: begin
        clk_en_d[tgt_q] = 1'b0;
        if (cnt_q == CntWidth'(HoldCycles - 1)) begin
          state_d = StRstOn;
          cnt_d   = '0;
        end
      end
      StRstOn: begin
        rst_n_d[tgt_q] = 1'b0;
        if (cnt_q == CntWidth'(HoldCycles - 1)) begin
          state_d = StPwrOff;
          cnt_d   = '0;
        end
      end
      StPwrOff: begin
        pwr_en_d[tgt_q] = 1'b0;
        on_d[tgt_q]     = 1'b0;
        state_d         = StIdle;
      end
      StPwrOn: begin
        pwr_en_d[tgt_q] = 1'b1;
        if (cnt_q == CntWidth'(SettleCycles - 1)) begin
          state_d = StClkOn;
          cnt_d   = '0;
        end
      end
      StClkOn: begin
        clk_en_d[tgt_q] = 1'b1;
        if (cnt_q == CntWidth'(HoldCycles - 1)) begin
          state_d = StRstOff;
          cnt_d   = '0;
        end
      end
      StRstOff: begin
        rst_n_d[tgt_q] = 1'b1;
        state_d        = StIsoOff;
        cnt_d          = '0;
      end
      StIsoOff: begin
        iso_req_d[tgt_q] = 1'b0;
        if (ack_valid && !ack) begin
          on_d[tgt_q] = 1'b1;
          state_d     = StIdle;
        end else if (cnt_q == CntWidth'(IsoTimeout)) begin
          // Isolation never confirmed released, but the cluster is powered and clocked.
          err_d[tgt_q] = 1'b1;
          on_d[tgt_q]  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef CHIMERA_PWR_SEQ_IRQ_EN
  logic done_q;

  // One-cycle pulse when a real sequence (including timeouts) returns to IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q != StIdle) && (state_d == StIdle);
    end
  end

  assign done_irq_o = done_q;
`endif

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign iso_req_o   = iso_req_q;
  assign clk_en_o    = clk_en_q;
  assign rst_no      = rst_n_q & {NumClusters{rst_ni}};
  assign pwr_en_o    = pwr_en_q;
  assign on_o        = on_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Directed bench for chimera_cluster_pwr_seq with default parameters (5 clusters, settle 16, hold 2, timeout 256).
module tb_chimera_cluster_pwr_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_cluster_i;
  logic       cmd_on_i;
  logic [4:0] iso_req_o;
  logic [4:0] iso_ack_i;
  logic [4:0] clk_en_o;
  logic [4:0] rst_no;
  logic [4:0] pwr_en_o;
  logic [4:0] on_o;
  logic [4:0] err_o;
  logic       busy_o;
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
  logic       done_irq_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  chimera_cluster_pwr_seq dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_cluster_i (cmd_cluster_i),
    .cmd_on_i      (cmd_on_i),
    .iso_req_o     (iso_req_o),
    .iso_ack_i     (iso_ack_i),
    .clk_en_o      (clk_en_o),
    .rst_no        (rst_no),
    .pwr_en_o      (pwr_en_o),
    .on_o          (on_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
    ,
    .done_irq_o    (done_irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Packed view: {iso, clk_en, rst_n, pwr_en, on, err, busy, ready}
  function automatic logic [31:0] snap();
    return {iso_req_o, clk_en_o, rst_no, pwr_en_o, on_o, err_o, busy_o, cmd_ready_o};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] iso, input logic [4:0] ce,
                                     input logic [4:0] rn, input logic [4:0] pw,
                                     input logic [4:0] on, input logic [4:0] er,
                                     input logic bsy, input logic rdy);
    return {iso, ce, rn, pw, on, er, bsy, rdy};
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Present a command; returns at the negedge after the accepting edge
  task automatic send(input logic [2:0] idx, input logic on);
    cmd_valid_i   = 1'b1;
    cmd_cluster_i = idx;
    cmd_on_i      = on;
    step();
    cmd_valid_i   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    e = mk(5'h00, 5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h00, 1'b0, 1'b1);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", snap(), e);
    end
    rst_ni = 1'b1;
    step();
    e = mk(5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b0, 1'b1);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_power_down();
    logic [31:0] e;
    logic        chk;
    send(3'd2, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) iso_ack_i[2] = 1'b1;
      chk = 1'b1;
      case (k)
        1, 7:   e = mk(5'h04, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b1, 1'b0);
        8, 9:   e = mk(5'h04, 5'h1B, 5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b1, 1'b0);
        10, 11: e = mk(5'h04, 5'h1B, 5'h1B, 5'h1F, 5'h1F, 5'h00, 1'b1, 1'b0);
        12:     e = mk(5'h04, 5'h1B, 5'h1B, 5'h1B, 5'h1B, 5'h00, 1'b0, 1'b1);
        default: begin
          chk = 1'b0;
          e   = '0;
        end
      endcase
      if (chk) begin
        n_cmp++;
        if (snap() !== e) begin
          n_err++;
          $display("FAIL pdown_c2 k=%0d: got %h want %h", k, snap(), e);
        end
      end
    end
  endtask

  task automatic test_power_up();
    logic [31:0] e;
    logic        chk;
    send(3'd2, 1'b1);
    for (int k = 1; k <= 23; k++) begin
      step();
      if (k == 20) iso_ack_i[2] = 1'b0;
      chk = 1'b1;
      case (k)
        1, 16:  e = mk(5'h04, 5'h1B, 5'h1B, 5'h1F, 5'h1B, 5'h00, 1'b1, 1'b0);
        17, 18: e = mk(5'h04, 5'h1F, 5'h1B, 5'h1F, 5'h1B, 5'h00, 1'b1, 1'b0);
        19:     e = mk(5'h04, 5'h1F, 5'h1F, 5'h1F, 5'h1B, 5'h00, 1'b1, 1'b0);
        20, 22: e = mk(5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1B, 5'h00, 1'b1, 1'b0);
        23:     e = mk(5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b0, 1'b1);
        default: begin
          chk = 1'b0;
          e   = '0;
        end
      endcase
      if (chk) begin
        n_cmp++;
        if (snap() !== e) begin
          n_err++;
          $display("FAIL pup_c2 k=%0d: got %h want %h", k, snap(), e);
        end
      end
    end
  endtask

  task automatic test_iso_timeout();
    logic [31:0] e;
    logic        chk;
    iso_ack_i[4] = 1'b0;
    send(3'd4, 1'b0);
    for (int k = 1; k <= 257; k++) begin
      step();
      chk = 1'b1;
      case (k)
        1, 256: e = mk(5'h10, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b1, 1'b0);
        257:    e = mk(5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h10, 1'b0, 1'b1);
        default: begin
          chk = 1'b0;
          e   = '0;
        end
      endcase
      if (chk) begin
        n_cmp++;
        if (snap() !== e) begin
          n_err++;
          $display("FAIL timeout_c4 k=%0d: got %h want %h", k, snap(), e);
        end
      end
    end
  endtask

  task automatic test_busy_noop();
    logic [31:0] e;
    int          cyc;
    send(3'd3, 1'b0);
    iso_ack_i[3] = 1'b1;
    n_cmp++;
    if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL busy_ready: got ready=%b busy=%b want ready=0 busy=1", cmd_ready_o, busy_o);
    end
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 50) begin
      step();
      cyc++;
      if (busy_o === 1'b1 && cmd_ready_o !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL busy_ready_k%0d: got ready=%b want 0", cyc, cmd_ready_o);
      end
    end
    n_cmp++;
    if (cyc != 8) begin
      n_err++;
      $display("FAIL pdown_c3_latency: got %0d cycles want 8", cyc);
    end
    e = mk(5'h08, 5'h17, 5'h17, 5'h17, 5'h17, 5'h10, 1'b0, 1'b1);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL pdown_c3_final: got %h want %h", snap(), e);
    end
    send(3'd1, 1'b1);
    step();
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL noop_c1: got %h want %h", snap(), e);
    end
    send(3'd7, 1'b0);
    step();
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL idx7: got %h want %h", snap(), e);
    end
    send(3'd4, 1'b1);
    e = mk(5'h08, 5'h17, 5'h17, 5'h17, 5'h17, 5'h00, 1'b0, 1'b1);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL err_clear_c4: got %h want %h", snap(), e);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    iso_ack_i[0] = 1'b1;
    step();
    step();
    send(3'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 3) begin
        e = mk(5'h09, 5'h17, 5'h17, 5'h17, 5'h17, 5'h00, 1'b1, 1'b0);
        n_cmp++;
        if (snap() !== e) begin
          n_err++;
          $display("FAIL pdown_c0 k=3: got %h want %h", snap(), e);
        end
      end else if (k == 4) begin
        e = mk(5'h09, 5'h16, 5'h17, 5'h17, 5'h17, 5'h00, 1'b1, 1'b0);
        n_cmp++;
        if (snap() !== e) begin
          n_err++;
          $display("FAIL pdown_c0 k=4: got %h want %h", snap(), e);
        end
      end
    end
    e = mk(5'h09, 5'h16, 5'h16, 5'h17, 5'h17, 5'h00, 1'b1, 1'b0);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL pdown_c0 k=6: got %h want %h", snap(), e);
    end
    rst_ni = 1'b0;
    #1;
    e = mk(5'h00, 5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h00, 1'b0, 1'b1);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", snap(), e);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    e = mk(5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00, 1'b0, 1'b1);
    n_cmp++;
    if (snap() !== e) begin
      n_err++;
      $display("FAIL async_reset_release: got %h want %h", snap(), e);
    end
  endtask

  initial begin
    rst_ni        = 1'b0;
    cmd_valid_i   = 1'b0;
    cmd_cluster_i = '0;
    cmd_on_i      = 1'b0;
    iso_ack_i     = '0;
    test_reset();
    test_power_down();
    test_power_up();
    test_iso_timeout();
    test_busy_noop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
